// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C SRAM master.
package i2c_pkg;

  // Controller phases; each non-idle state lasts a whole number of bit-times.
  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAddrW,
    StMem,
    StWdata,
    StRestart,
    StAddrR,
    StRdata,
    StAck,
    StNack,
    StStop
  } i2c_master_state_t;

  // Which byte the pending ACK bit belongs to; selects the state after ACK.
  typedef enum logic [1:0] {
    StepAddrW,
    StepMem,
    StepWdata,
    StepAddrR
  } i2c_step_t;

  localparam logic        I2C_RW_WRITE = 1'b0;
  localparam logic        I2C_RW_READ  = 1'b1;
  localparam int unsigned I2C_QUARTERS = 4;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-period timer: tick on the last clock of each quarter, phase counts Q0..Q3.
module i2c_quarter_timer
  import i2c_pkg::*;
#(
  parameter int unsigned DIV_QUARTER = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int unsigned CntW = $clog2(DIV_QUARTER);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_QUARTER - 1);
  localparam logic [1:0] PhaseLast = 2'(I2C_QUARTERS - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      phase_q, phase_d;

  assign tick  = run && (cnt_q == CntLast);
  assign phase = phase_q;

  // Next count/phase; both restart from Q0 whenever the master is idle.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run) begin
      cnt_d   = '0;
      phase_d = 2'd0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = (phase_q == PhaseLast) ? 2'd0 : phase_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Timer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/i2c_sram_master.sv
// Single-master I2C initiator: one random write or random read per request.
module i2c_sram_master
  import i2c_pkg::*;
#(
  parameter int unsigned DIV_QUARTER = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] mem_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       SCL,
  inout  wire        SDA
);

  i2c_master_state_t state_q, state_d;
  i2c_step_t         step_q, step_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] mem_q, mem_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rdata_q, rdata_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sda_low_q, sda_low_d;
  logic       done_q, done_d;
  logic       ack_err_q, ack_err_d;

  logic       tick;
  logic [1:0] phase;
  logic       sda_in;
  logic       q1_start, q2_start, q2_sample, bit_end;

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign ack_error = ack_err_q;
  assign rdata     = rdata_q;

  // Open-drain: only ever pull low or release.
  assign SDA    = sda_low_q ? 1'b0 : 1'bz;
  assign sda_in = SDA;

  i2c_quarter_timer #(
    .DIV_QUARTER(DIV_QUARTER)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .run  (busy),
    .tick (tick),
    .phase(phase)
  );

  // tick marks the last clock of the current quarter, so these are quarter boundaries.
  assign q1_start  = tick && (phase == 2'd0);
  assign q2_start  = tick && (phase == 2'd1);
  assign q2_sample = tick && (phase == 2'd2);
  assign bit_end   = tick && (phase == 2'd3);

  // SCL is decoded from the registered state/phase; high in Q2..Q3 of ordinary bits.
  always_comb begin
    SCL = 1'b1;
    unique case (state_q)
      StIdle, StStart: SCL = 1'b1;
      StRestart:       SCL = (phase != 2'd0);
      default:         SCL = phase[1];
    endcase
  end

  // Next-state and datapath control for the transfer sequence.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    mem_d     = mem_q;
    wdata_d   = wdata_q;
    shift_d   = shift_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    sda_low_d = sda_low_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;

    unique case (state_q)
      StIdle: begin
        sda_low_d = 1'b0;
        if (start) begin
          rw_d      = rw;
          dev_d     = dev_addr;
          mem_d     = mem_addr;
          wdata_d   = wdata;
          ack_err_d = 1'b0;
          state_d   = StStart;
        end
      end

      StStart, StRestart: begin
        if (q2_start) sda_low_d = 1'b1;
        if (bit_end) begin
          cnt_d = 4'd0;
          if (state_q == StStart) begin
            state_d = StAddrW;
            shift_d = {dev_q, 1'b0};
            step_d  = StepAddrW;
          end else begin
            state_d = StAddrR;
            shift_d = {dev_q, 1'b1};
            step_d  = StepAddrR;
          end
        end
      end

      StAddrW, StMem, StWdata, StAddrR: begin
        if (q1_start) sda_low_d = ~shift_q[7];
        if (bit_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            state_d = StAck;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      StAck: begin
        if (q1_start) sda_low_d = 1'b0;
        if (q2_sample && sda_in) ack_err_d = 1'b1;
        if (bit_end) begin
          if (ack_err_q) begin
            state_d   = StStop;
            sda_low_d = 1'b1;
          end else begin
            unique case (step_q)
              StepAddrW: begin
                state_d = StMem;
                shift_d = mem_q;
                step_d  = StepMem;
              end
              StepMem: begin
                if (rw_q == I2C_RW_WRITE) begin
                  state_d = StWdata;
                  shift_d = wdata_q;
                  step_d  = StepWdata;
                end else begin
                  state_d   = StRestart;
                  sda_low_d = 1'b0;
                end
              end
              StepWdata: begin
                state_d   = StStop;
                sda_low_d = 1'b1;
              end
              StepAddrR: begin
                state_d   = StRdata;
                sda_low_d = 1'b0;
              end
            endcase
          end
        end
      end

      StRdata: begin
        if (q2_sample) rdata_d = {rdata_q[6:0], sda_in};
        if (bit_end) begin
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            state_d = StNack;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      // SDA stays released for the whole bit: the master NACKs the only data byte.
      StNack: begin
        if (bit_end) begin
          state_d   = StStop;
          sda_low_d = 1'b1;
        end
      end

      StStop: begin
        if (q2_sample) sda_low_d = 1'b0;
        if (bit_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Controller registers; reset abandons any transfer without a STOP.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      step_q    <= StepAddrW;
      rw_q      <= 1'b0;
      dev_q     <= 7'd0;
      mem_q     <= 8'd0;
      wdata_q   <= 8'd0;
      shift_q   <= 8'd0;
      rdata_q   <= 8'd0;
      cnt_q     <= 4'd0;
      sda_low_q <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      mem_q     <= mem_d;
      wdata_q   <= wdata_d;
      shift_q   <= shift_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      sda_low_q <= sda_low_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
    end
  end

endmodule
